imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a byte stream (valid/ready), packs it into
//  32-bit little-endian words and drives the imem write port from word 0 upward.

---
 rtl/loader_pkg.sv | 33 +++
 rtl/word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Depth shared with instruction_memory, in 32-bit words.
  localparam int IMEM_DEPTH_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  // States in which the loader is waiting for stream bytes.
  function automatic logic state_takes_bytes(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
  endfunction

  // States in which a start pulse begins a new load.
  function automatic logic state_accepts_start(input loader_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs four stream bytes into one little-endian 32-bit word.
//               First byte lands in bits[7:0], fourth in bits[31:24].
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word;

  // Byte lane write and lane counter; the counter wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_word     <= 32'd0;
    end else if (i_clear) begin
      r_byte_cnt <= 2'd0;
    end else if (i_load) begin
      case (r_byte_cnt)
        2'd0:    r_word[7:0]   <= i_byte;
        2'd1:    r_word[15:8]  <= i_byte;
        2'd2:    r_word[23:16] <= i_byte;
        default: r_word[31:24] <= i_byte;
      endcase
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  // Asserted in the cycle whose byte completes the word.
  assign o_word_full = i_load && (r_byte_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a length-prefixed byte stream, packs it into 32-bit
//               words and writes them to instruction memory from word 0 up.
//               Holds the core in reset while loading or after an error.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter  int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter  int unsigned TIMEOUT_CYC = 100000,
  localparam int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_waddr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_written
);

  localparam logic [15:0] c_DEPTH16    = 16'(DEPTH_WORDS);
  localparam logic [31:0] c_IDLE_LAST  = 32'(TIMEOUT_CYC - 1);

  loader_state_t   r_state;
  loader_state_t   w_next_state;

  logic [7:0]      r_len_lo;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_idx;
  logic [31:0]     r_idle_cnt;

  logic            w_in_ready;
  logic            w_xfer;
  logic            w_start_ok;
  logic [15:0]     w_len16;
  logic            w_len_bad;
  logic            w_timeout;
  logic [ADDR_W:0] w_idx_next;
  logic            w_word_full;
  logic [31:0]     w_word;

  // Ready depends only on the registered state, so no input reaches an output.
  assign w_in_ready = state_takes_bytes(r_state);
  assign w_xfer     = i_in_valid && w_in_ready;
  assign w_start_ok = i_start && state_accepts_start(r_state);
  assign w_len16    = {i_in_data, r_len_lo};
  assign w_len_bad  = (w_len16 == 16'd0) || (w_len16 > c_DEPTH16);
  assign w_timeout  = w_in_ready && !w_xfer && (r_idle_cnt == c_IDLE_LAST);
  assign w_idx_next = r_idx + 1'b1;

  word_assembler u_word_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_load      (w_xfer && (r_state == DATA)),
    .i_byte      (i_in_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    o_imem_we    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_core_rst_n = 1'b0;
    case (r_state)
      IDLE: begin
        o_core_rst_n = 1'b1;
        if (w_start_ok) w_next_state = LEN_LO;
      end
      LEN_LO: begin
        o_busy = 1'b1;
        if (w_timeout)   w_next_state = ERROR;
        else if (w_xfer) w_next_state = LEN_HI;
      end
      LEN_HI: begin
        o_busy = 1'b1;
        if (w_timeout)   w_next_state = ERROR;
        else if (w_xfer) w_next_state = w_len_bad ? ERROR : DATA;
      end
      DATA: begin
        o_busy = 1'b1;
        if (w_timeout)        w_next_state = ERROR;
        else if (w_word_full) w_next_state = WRITE;
      end
      WRITE: begin
        o_busy       = 1'b1;
        o_imem_we    = 1'b1;
        w_next_state = (w_idx_next == r_len) ? DONE : DATA;
      end
      DONE: begin
        o_done       = 1'b1;
        o_core_rst_n = 1'b1;
        if (w_start_ok) w_next_state = LEN_LO;
      end
      ERROR: begin
        o_error = 1'b1;
        if (w_start_ok) w_next_state = LEN_LO;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Capture the two length bytes; only the in-range low bits are kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_lo <= 8'd0;
      r_len    <= '0;
    end else if ((r_state == LEN_LO) && w_xfer) begin
      r_len_lo <= i_in_data;
    end else if ((r_state == LEN_HI) && w_xfer) begin
      r_len    <= w_len16[ADDR_W:0];
    end
  end

  // Word index doubles as the words-written count; advances once per WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_start_ok) begin
      r_idx <= '0;
    end else if (r_state == WRITE) begin
      r_idx <= w_idx_next;
    end
  end

  // Idle counter: cleared on every transfer and state change, counts while waiting for bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_cnt <= 32'd0;
    end else if (w_xfer || (w_next_state != r_state)) begin
      r_idle_cnt <= 32'd0;
    end else if (w_in_ready) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign o_in_ready      = w_in_ready;
  assign o_imem_waddr    = r_idx[ADDR_W-1:0];
  assign o_imem_wdata    = w_word;
  assign o_words_written = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic              i_in_valid;
  logic [7:0]        i_in_data;
  logic              o_in_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_waddr;
  logic [31:0]       o_imem_wdata;
  logic              o_core_rst_n;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [ADDR_W:0]   o_words_written;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  logic [5:0]  log_a [0:255];
  logic [31:0] log_d [0:255];
  int          ready_viol = 0;
  int          crst_viol  = 0;

  imem_loader #(.DEPTH_WORDS(64), .TIMEOUT_CYC(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_in_valid      (i_in_valid),
    .i_in_data       (i_in_data),
    .o_in_ready      (o_in_ready),
    .o_imem_we       (o_imem_we),
    .o_imem_waddr    (o_imem_waddr),
    .o_imem_wdata    (o_imem_wdata),
    .o_core_rst_n    (o_core_rst_n),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error         (o_error),
    .o_words_written (o_words_written)
  );

  always #5 clk = ~clk;

  // Write log and protocol watchers, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_imem_we) begin
      if (wr_cnt < 256) begin
        log_a[wr_cnt] = o_imem_waddr;
        log_d[wr_cnt] = o_imem_wdata;
      end
      wr_cnt++;
    end
    if (o_imem_we && o_in_ready) ready_viol++;
    if (o_busy && o_core_rst_n)  crst_viol++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    i_in_valid = 1'b1;
    i_in_data  = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (o_in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    i_in_valid = 1'b0;
    check("byte_accept", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int base;
    int errs;
    logic [31:0] exp_w;
    rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", o_in_ready, 0);
    check("rst_we", o_imem_we, 0);
    check("rst_waddr", o_imem_waddr, 0);
    check("rst_wdata", o_imem_wdata, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_ww", o_words_written, 0);
    check("rst_core_rst_n", o_core_rst_n, 1);

    // 1: two-word program
    base = wr_cnt;
    pulse_start();
    check("t1_busy", o_busy, 1);
    check("t1_core_rst_low", o_core_rst_n, 0);
    check("t1_ready", o_in_ready, 1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    check("t1_we0", o_imem_we, 1);
    check("t1_waddr0", o_imem_waddr, 0);
    check("t1_wdata0", o_imem_wdata, 32'h00A00513);
    send_byte(8'hB3); send_byte(8'h05); send_byte(8'hB5); send_byte(8'h00);
    check("t1_we1", o_imem_we, 1);
    check("t1_waddr1", o_imem_waddr, 1);
    @(posedge clk); #1;
    check("t1_done", o_done, 1);
    check("t1_core_rst_high", o_core_rst_n, 1);
    check("t1_ww", o_words_written, 2);
    check("t1_busy_off", o_busy, 0);
    check("t1_nwrites", wr_cnt - base, 2);
    check("t1_log_a0", log_a[base], 0);
    check("t1_log_d0", log_d[base], 32'h00A00513);
    check("t1_log_a1", log_a[base+1], 1);
    check("t1_log_d1", log_d[base+1], 32'h00B505B3);

    // 2: bad lengths
    base = wr_cnt;
    pulse_start();
    check("t2_ww_cleared", o_words_written, 0);
    send_byte(8'h00); send_byte(8'h00);
    check("t2_err_zero", o_error, 1);
    check("t2_core_rst_err", o_core_rst_n, 0);
    check("t2_ready_err", o_in_ready, 0);
    pulse_start();
    check("t2_err_cleared", o_error, 0);
    check("t2_busy", o_busy, 1);
    send_byte(8'h41); send_byte(8'h00);
    check("t2_err_big", o_error, 1);
    repeat (3) @(posedge clk); #1;
    check("t2_no_writes", wr_cnt - base, 0);

    // 3: full-depth program with irregular source gaps
    base = wr_cnt;
    pulse_start();
    send_byte(8'h40); send_byte(8'h00);
    for (int w = 0; w < 64; w++) begin
      for (int j = 0; j < 4; j++) begin
        repeat ((w * 4 + j) % 6) @(posedge clk);
        #1;
        send_byte(8'(((w * 4 + j) * 3 + 1) & 255));
      end
    end
    @(posedge clk); #1;
    check("t3_done", o_done, 1);
    check("t3_ww", o_words_written, 64);
    check("t3_nwrites", wr_cnt - base, 64);
    errs = 0;
    for (int w = 0; w < 64; w++) begin
      for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'(((w * 4 + j) * 3 + 1) & 255);
      if (log_a[base + w] !== 6'(w) || log_d[base + w] !== exp_w) errs++;
    end
    check("t3_order_data", errs, 0);
    check("t3_last_addr", log_a[base + 63], 63);

    // 4: timeout after a partial word
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    repeat (15) @(posedge clk); #1;
    check("t4_not_yet", o_error, 0);
    check("t4_still_busy", o_busy, 1);
    @(posedge clk); #1;
    check("t4_timeout_err", o_error, 1);
    check("t4_ww", o_words_written, 1);
    check("t4_nwrites", wr_cnt - base, 1);
    check("t4_word0", log_d[base], 32'h44332211);

    // 5: start ignored in DATA, then reset mid-load
    base = wr_cnt;
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int k = 0; k < 12; k++) send_byte(8'(k + 8'h80));
    @(posedge clk); #1;
    check("t5_ww3", o_words_written, 3);
    pulse_start();
    check("t5_ign_busy", o_busy, 1);
    check("t5_ign_ww", o_words_written, 3);
    check("t5_ign_ready", o_in_ready, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_done0", o_done, 0);
    check("t5_busy0", o_busy, 0);
    check("t5_core_rst_n", o_core_rst_n, 1);
    check("t5_ww0", o_words_written, 0);
    i_in_valid = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("t5_ready_idle", o_in_ready, 0);
    i_in_valid = 1'b0;
    check("t5_nwrites", wr_cnt - base, 3);
    check("t5_word2", log_d[base + 2], 32'h8B8A8988);

    // 6: byte held through WRITE is taken the next cycle
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    i_in_valid = 1'b1;
    i_in_data  = 8'hB1;
    @(negedge clk);
    check("t6_ready_in_write", o_in_ready, 0);
    check("t6_we", o_imem_we, 1);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    @(posedge clk); #1;
    check("t6_done", o_done, 1);
    check("t6_ww", o_words_written, 2);
    check("t6_nwrites", wr_cnt - base, 2);
    check("t6_word0", log_d[base], 32'hA4A3A2A1);
    check("t6_word1", log_d[base + 1], 32'hB4B3B2B1);
    check("ready_during_write", ready_viol, 0);
    check("core_rst_while_busy", crst_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
